// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// A 32-bit value is shown as hex digits, one digit per scan slot. Each slot
// starts with a short all-anodes-off window to stop ghosting between digits.
// New values go into a shadow register and are moved to the active register
// only at frame start, so a frame never mixes two values.
//
// load_in is a one-cycle strobe with no back-pressure: every cycle it is high,
// the inputs are captured into the shadow, replacing any uncommitted value.
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 8,
   parameter int CLK_DIV      = 100000,
   parameter int BLANK_CYCLES = 2000
) (
   input  logic        clk_100mhz,
   input  logic        rst_in,
   input  logic [31:0] val_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  en_in,
   input  logic        lz_en_in,
   input  logic        load_in,
   output logic [6:0]  cat_out,
   output logic        dp_out,
   output logic [7:0]  an_out,
   output logic        frame_sync_out,
   output logic        pending_out
);

   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] BLANK_END  = DIV_W'(BLANK_CYCLES);
   localparam logic [2:0]       DIGIT_LAST = 3'(NUM_DIGITS - 1);

   typedef struct packed {
      logic [31:0] val;
      logic [7:0]  dp;
      logic [7:0]  en;
      logic        lz_en;
   } disp_cfg_t;

   // Scan position
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [2:0]       digit_q, digit_d;
   logic             slot_end;
   logic             frame_start;

   // Double buffer
   disp_cfg_t        shadow_q, shadow_d;
   disp_cfg_t        active_q, active_d;
   logic             pending_q, pending_d;

   // Registered pin drivers
   logic [7:0]       an_q, an_d;
   logic [6:0]       cat_q, cat_d;
   logic             dp_q, dp_d;
   logic             frame_sync_q, frame_sync_d;

   // Digit lighting helpers
   logic [7:0]       upper_zero;
   logic [7:0]       lit;
   logic             zero_acc;
   logic [3:0]       nibble;

   // Hex nibble to active-low segments {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
      logic [6:0] seg;
      case (n)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

   // Prescaler and digit counter: one slot per CLK_DIV cycles, digits wrap per frame
   always_comb begin
      div_cnt_d   = div_cnt_q;
      digit_d     = digit_q;
      slot_end    = (div_cnt_q == DIV_LAST);
      frame_start = slot_end && (digit_q == DIGIT_LAST);
      if (slot_end) begin
         div_cnt_d = '0;
         if (digit_q == DIGIT_LAST) begin
            digit_d = 3'd0;
         end else begin
            digit_d = digit_q + 3'd1;
         end
      end else begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
   end

   // Shadow capture and frame-aligned commit; a load in the commit cycle stays pending
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (frame_start && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (load_in) begin
         shadow_d.val   = val_in;
         shadow_d.dp    = dp_in;
         shadow_d.en    = en_in;
         shadow_d.lz_en = lz_en_in;
         pending_d      = 1'b1;
      end
   end

   // Per-digit lit mask; upper_zero[i] means nibbles i..NUM_DIGITS-1 are all zero
   always_comb begin
      upper_zero = '0;
      lit        = '0;
      zero_acc   = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         if (i < NUM_DIGITS) begin
            zero_acc = zero_acc & (active_q.val[i*4 +: 4] == 4'h0);
         end
         upper_zero[i] = zero_acc;
      end
      for (int i = 0; i < 8; i++) begin
         lit[i] = (i < NUM_DIGITS) && active_q.en[i] &&
                  !(active_q.lz_en && (i != 0) && upper_zero[i]);
      end
   end

   // Pin drivers for the current scan position; everything dark unless one digit lights
   always_comb begin
      an_d         = 8'hFF;
      cat_d        = 7'h7F;
      dp_d         = 1'b1;
      nibble       = active_q.val[{digit_q, 2'b00} +: 4];
      frame_sync_d = frame_start;
      if (lit[digit_q] && (div_cnt_q >= BLANK_END)) begin
         an_d[digit_q] = 1'b0;
         cat_d         = hex_to_seg(nibble);
         dp_d          = ~active_q.dp[digit_q];
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_100mhz) begin
      if (rst_in) begin
         div_cnt_q    <= '0;
         digit_q      <= 3'd0;
         shadow_q     <= '0;
         active_q     <= '0;
         pending_q    <= 1'b0;
         an_q         <= 8'hFF;
         cat_q        <= 7'h7F;
         dp_q         <= 1'b1;
         frame_sync_q <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         digit_q      <= digit_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         an_q         <= an_d;
         cat_q        <= cat_d;
         dp_q         <= dp_d;
         frame_sync_q <= frame_sync_d;
      end
   end

   assign an_out         = an_q;
   assign cat_out        = cat_q;
   assign dp_out         = dp_q;
   assign frame_sync_out = frame_sync_q;
   assign pending_out    = pending_q;

endmodule
